// File: rtl/pn_sync_checker_if.sv
// rtl/pn_sync_checker_if.sv - bit stream and status bundle for the PN sync checker
interface pn_sync_checker_if #(
    parameter int CNT_W = 16
);
    logic             bit_valid;
    logic             bit_in;
    logic             clr_cnt;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output bit_valid, bit_in, clr_cnt,
        input  locked, err, err_cnt, bit_cnt
    );

    modport slave (
        input  bit_valid, bit_in, clr_cnt,
        output locked, err, err_cnt, bit_cnt
    );
endinterface

// File: rtl/pn_sync_checker.sv
// rtl/pn_sync_checker.sv - self-synchronising PN sequence checker with lock and error counting
module pn_sync_checker #(
    parameter int N         = 5,
    parameter int LOCK_CNT  = 16,
    parameter int WIN       = 32,
    parameter int LOSS_ERRS = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    pn_sync_checker_if.slave bus
);
    localparam bit SUPPORTED = (N == 5) || (N == 4);
    // Register is at least 5 wide so both tap sets index legally; bits above N stay zero.
    localparam int RW = (N > 5) ? N : 5;
    localparam logic [RW-1:0] R_MASK = {RW{1'b1}} >> (RW - N);
    localparam int FW = $clog2(N + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int EW = $clog2(LOSS_ERRS + 1);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    r_q, r_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_q, win_d;
    logic [EW-1:0]    werr_q, werr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic             p;
    logic             mism;
    logic [CNT_W-1:0] err_base;
    logic [CNT_W-1:0] bit_base;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_d     = win_q;
        werr_d    = werr_q;
        err_d     = 1'b0;
        p         = (N == 5) ? (r_q[4] ^ r_q[2]) : (r_q[3] ^ r_q[2]);
        mism      = bus.bit_in != p;
        err_base  = bus.clr_cnt ? '0 : err_cnt_q;
        bit_base  = bus.clr_cnt ? '0 : bit_cnt_q;
        err_cnt_d = err_base;
        bit_cnt_d = bit_base;

        if (bus.bit_valid) begin
            case (state_q)
                HUNT: begin
                    r_d    = {r_q[RW-2:0], bus.bit_in} & R_MASK;
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FW'(N - 1)) begin
                        state_d = CHECK;
                        match_d = '0;
                    end
                end
                CHECK: begin
                    r_d = {r_q[RW-2:0], bus.bit_in} & R_MASK;
                    // An all-zero register predicts zero forever, so it never counts as a match.
                    if (mism || (r_q == '0) || !SUPPORTED) begin
                        match_d = '0;
                    end else if (match_q == MW'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                LOCKED: begin
                    r_d       = {r_q[RW-2:0], p} & R_MASK;
                    bit_cnt_d = sat_inc(bit_base);
                    if (mism) begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(err_base);
                    end
                    if (mism && (werr_q == EW'(LOSS_ERRS - 1))) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else if (win_q == WW'(WIN - 1)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + 1'b1;
                        werr_d = werr_q + EW'(mism);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            r_q       <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_q     <= '0;
            werr_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_q     <= win_d;
            werr_q    <= werr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bus.locked  = (state_q == LOCKED);
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.bit_cnt = bit_cnt_q;
endmodule

// File: tb/tb_pn_sync_checker.sv
// tb/tb_pn_sync_checker.sv - bench for pn_sync_checker with a sequence-level reference model
module tb_pn_sync_checker;
    localparam int LOCK_CNT  = 16;
    localparam int WIN       = 32;
    localparam int LOSS_ERRS = 4;
    localparam int HCAP      = 16384;
    localparam int M_HUNT    = 0;
    localparam int M_CHECK   = 1;
    localparam int M_LOCK    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pn_sync_checker_if #(.CNT_W(16)) if5 ();
    pn_sync_checker_if #(.CNT_W(16)) if4 ();
    pn_sync_checker_if #(.CNT_W(4))  ifs ();

    pn_sync_checker #(.N(5), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .LOSS_ERRS(LOSS_ERRS), .CNT_W(16))
        u5 (.clk(clk), .rst(rst), .bus(if5));
    pn_sync_checker #(.N(4), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .LOSS_ERRS(LOSS_ERRS), .CNT_W(16))
        u4 (.clk(clk), .rst(rst), .bus(if4));
    pn_sync_checker #(.N(5), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .LOSS_ERRS(LOSS_ERRS), .CNT_W(4))
        us (.clk(clk), .rst(rst), .bus(ifs));

    int checks = 0;
    int errors = 0;

    // Reference model: full received history plus plain counters per instance
    bit hb[3][HCAP];
    int hl[3];
    int mode[3], fill[3], match[3], wbits[3], werr[3], errc[3], bitc[3];
    bit experr[3];
    int nn[3]   = '{5, 4, 5};
    int cmax[3] = '{65535, 65535, 15};

    // Stimulus PN source
    bit g[$];
    int gn;
    int gi;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit hist_pred(input int k);
        // s[n] = s[n-N] ^ s[n-3]
        return hb[k][hl[k] - nn[k]] ^ hb[k][hl[k] - 3];
    endfunction

    function automatic bit hist_zero(input int k);
        for (int i = 1; i <= nn[k]; i++)
            if (hb[k][hl[k] - i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void hist_push(input int k, input bit b);
        if (hl[k] < HCAP) begin
            hb[k][hl[k]] = b;
            hl[k]++;
        end
    endfunction

    function automatic int sat(input int v, input int k);
        return (v > cmax[k]) ? cmax[k] : v;
    endfunction

    function automatic void model_reset(input int k);
        hl[k] = 0; mode[k] = M_HUNT; fill[k] = 0; match[k] = 0;
        wbits[k] = 0; werr[k] = 0; errc[k] = 0; bitc[k] = 0; experr[k] = 1'b0;
    endfunction

    function automatic void model_step(input int k, input bit v, input bit b, input bit c);
        bit p;
        bit ok;
        experr[k] = 1'b0;
        if (c) begin
            errc[k] = 0;
            bitc[k] = 0;
        end
        if (!v) return;
        if (mode[k] == M_HUNT) begin
            hist_push(k, b);
            fill[k]++;
            if (fill[k] == nn[k]) begin
                mode[k]  = M_CHECK;
                match[k] = 0;
            end
        end else if (mode[k] == M_CHECK) begin
            ok = (hist_pred(k) == b) && !hist_zero(k);
            hist_push(k, b);
            if (!ok) match[k] = 0;
            else begin
                match[k]++;
                if (match[k] == LOCK_CNT) begin
                    mode[k] = M_LOCK; wbits[k] = 0; werr[k] = 0;
                end
            end
        end else begin
            p = hist_pred(k);
            hist_push(k, p);
            bitc[k] = sat(bitc[k] + 1, k);
            if (b != p) begin
                experr[k] = 1'b1;
                errc[k]   = sat(errc[k] + 1, k);
                werr[k]++;
                if (werr[k] == LOSS_ERRS) begin
                    mode[k] = M_HUNT;
                    fill[k] = 0;
                    return;
                end
            end
            wbits[k]++;
            if (wbits[k] == WIN) begin
                wbits[k] = 0;
                werr[k]  = 0;
            end
        end
    endfunction

    task automatic compare_all();
        int l, e, ec, bc;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin l = int'(if5.locked); e = int'(if5.err); ec = int'(if5.err_cnt); bc = int'(if5.bit_cnt); end
                1: begin l = int'(if4.locked); e = int'(if4.err); ec = int'(if4.err_cnt); bc = int'(if4.bit_cnt); end
                default: begin l = int'(ifs.locked); e = int'(ifs.err); ec = int'(ifs.err_cnt); bc = int'(ifs.bit_cnt); end
            endcase
            check($sformatf("locked[%0d]", k), l, int'(mode[k] == M_LOCK));
            check($sformatf("err[%0d]", k), e, int'(experr[k]));
            check($sformatf("err_cnt[%0d]", k), ec, errc[k]);
            check($sformatf("bit_cnt[%0d]", k), bc, bitc[k]);
        end
    endtask

    task automatic cyc(input bit v, input bit b, input bit c, input bit r);
        rst = r;
        if5.bit_valid = v; if5.bit_in = b; if5.clr_cnt = c;
        if4.bit_valid = v; if4.bit_in = b; if4.clr_cnt = c;
        ifs.bit_valid = v; ifs.bit_in = b; ifs.clr_cnt = c;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (r) model_reset(k);
            else   model_step(k, v, b, c);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic gen_init(input int n);
        int seed;
        g.delete();
        gn   = n;
        gi   = 0;
        seed = int'($urandom_range(1, (1 << n) - 1));
        for (int i = n - 1; i >= 0; i--) g.push_back(bit'((seed >> i) & 1));
    endtask

    function automatic bit pn_next();
        bit b;
        if (gi >= g.size()) g.push_back(g[g.size() - gn] ^ g[g.size() - 3]);
        b = g[gi];
        gi++;
        return b;
    endfunction

    task automatic send(input bit inv);
        bit b;
        b = pn_next() ^ inv;
        cyc(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic acquire5(input string tag);
        for (int i = 1; i <= 21; i++) begin
            send(1'b0);
            if (i == 20) check({tag, "_pre_lock"}, int'(if5.locked), 0);
            if (i == 21) check({tag, "_lock"}, int'(if5.locked), 1);
        end
    endtask

    initial begin
        int a0, a1, a2, vcount;
        bit any_lock;
        rst = 1'b1;
        if5.bit_valid = 0; if5.bit_in = 0; if5.clr_cnt = 0;
        if4.bit_valid = 0; if4.bit_in = 0; if4.clr_cnt = 0;
        ifs.bit_valid = 0; ifs.bit_in = 0; ifs.clr_cnt = 0;
        for (int k = 0; k < 3; k++) model_reset(k);
        @(negedge clk);

        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("rst_locked", int'(if5.locked), 0);
        check("rst_err", int'(if5.err), 0);
        check("rst_err_cnt", int'(if5.err_cnt), 0);
        check("rst_bit_cnt", int'(if5.bit_cnt), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Acquisition and 100 clean bits
        gen_init(5);
        acquire5("acq");
        for (int i = 0; i < 100; i++) send(1'b0);
        check("acq_bit_cnt", int'(if5.bit_cnt), 100);
        check("acq_err_cnt", int'(if5.err_cnt), 0);
        check("sat_bit_cnt", int'(ifs.bit_cnt), 15);

        // Single inverted bit: one pulse, no propagation
        send(1'b1);
        check("single_err", int'(if5.err), 1);
        check("single_err_cnt", int'(if5.err_cnt), 1);
        for (int i = 0; i < 31; i++) send(1'b0);
        check("single_hold_cnt", int'(if5.err_cnt), 1);
        check("single_hold_lock", int'(if5.locked), 1);

        // Clear on an idle cycle, then four errors in one window
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_idle", int'(if5.err_cnt), 0);
        check("clr_keeps_lock", int'(if5.locked), 1);
        for (int i = 1; i <= 4; i++) begin
            send(1'b1);
            if (i == 3) check("loss_pre", int'(if5.locked), 1);
        end
        check("loss_locked", int'(if5.locked), 0);
        check("loss_err", int'(if5.err), 1);
        check("loss_err_cnt", int'(if5.err_cnt), 4);
        acquire5("relock");

        // Three errors per window over six windows keeps lock
        for (int w = 0; w < 6; w++) begin
            a0 = int'($urandom_range(0, 9));
            a1 = int'($urandom_range(10, 20));
            a2 = int'($urandom_range(21, 31));
            for (int j = 0; j < 32; j++) send(bit'((j == a0) || (j == a1) || (j == a2)));
        end
        check("spread_lock", int'(if5.locked), 1);
        check("spread_err_cnt", int'(if5.err_cnt), 22);
        check("sat_err_cnt", int'(ifs.err_cnt), 15);

        // Randomised gaps, errors and clears against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0)
                cyc(1'b1, pn_next() ^ ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0), 1'b0);
            else
                cyc(1'b0, 1'($urandom), ($urandom_range(0, 63) == 0), 1'b0);
        end

        // Reset while locked with three errors
        do_reset();
        gen_init(5);
        acquire5("rst_mid");
        for (int i = 0; i < 3; i++) begin
            send(1'b1);
            send(1'b0);
        end
        check("rst_mid_err_cnt", int'(if5.err_cnt), 3);
        cyc(1'b1, pn_next(), 1'b0, 1'b1);
        check("rst_mid_locked", int'(if5.locked), 0);
        check("rst_mid_cleared", int'(if5.err_cnt), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Clear coinciding with an error
        gen_init(5);
        acquire5("clr_err");
        send(1'b1);
        send(1'b0);
        cyc(1'b1, pn_next() ^ 1'b1, 1'b1, 1'b0);
        check("clr_err_cnt", int'(if5.err_cnt), 1);
        check("clr_bit_cnt", int'(if5.bit_cnt), 1);
        check("clr_err_pulse", int'(if5.err), 1);

        // All-zero stream never locks
        do_reset();
        any_lock = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            any_lock |= if5.locked;
        end
        check("zero_never_lock", int'(any_lock), 0);
        check("zero_err_cnt", int'(if5.err_cnt), 0);

        // Valid gaps: lock point counted in valid bits only
        do_reset();
        gen_init(5);
        vcount = 0;
        for (int i = 0; i < 42; i++) begin
            if (i % 2 == 0) begin
                send(1'b0);
                vcount++;
                if (vcount == 20) check("gap_pre_lock", int'(if5.locked), 0);
                if (vcount == 21) check("gap_lock", int'(if5.locked), 1);
            end else begin
                cyc(1'b0, 1'($urandom), 1'b0, 1'b0);
            end
        end
        check("gap_frozen_lock", int'(if5.locked), 1);
        check("gap_bit_cnt", int'(if5.bit_cnt), 0);

        // N=4, period-15 sequence
        do_reset();
        gen_init(4);
        for (int i = 1; i <= 20; i++) begin
            send(1'b0);
            if (i == 19) check("n4_pre_lock", int'(if4.locked), 0);
            if (i == 20) check("n4_lock", int'(if4.locked), 1);
        end
        for (int i = 0; i < 30; i++) send(1'b0);
        check("n4_err_cnt", int'(if4.err_cnt), 0);
        check("n4_bit_cnt", int'(if4.bit_cnt), 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
